// File: rtl/music_playback_ctrl_pkg.sv
// Shared key codes, FSM state and decoded-command types for the music playback controller.
package music_ctrl_pkg;

  localparam logic [7:0] KEY_F = 8'h46;
  localparam logic [7:0] KEY_B = 8'h42;
  localparam logic [7:0] KEY_E = 8'h45;
  localparam logic [7:0] KEY_D = 8'h44;
  localparam logic [7:0] KEY_R = 8'h52;
  localparam logic [7:0] KEY_U = 8'h55;
  localparam logic [7:0] KEY_L = 8'h4C;
  localparam logic [7:0] KEY_N = 8'h4E;

  typedef enum logic {IDLE, WAIT_ACK} play_state_t;

  typedef enum logic [3:0] {
    CMD_NONE, CMD_FWD, CMD_BWD, CMD_PLAY, CMD_PAUSE,
    CMD_RESTART, CMD_FASTER, CMD_SLOWER, CMD_NORMAL
  } cmd_t;

  // Maps 'a'..'z' onto 'A'..'Z' when folding is enabled.
  function automatic logic [7:0] fold_case(input logic [7:0] c, input logic en);
    logic [7:0] r;
    r = c;
    if (en && (c >= 8'h61) && (c <= 8'h7A)) r = c - 8'h20;
    return r;
  endfunction

endpackage

// File: rtl/music_playback_ctrl_if.sv
// Flash read handshake between the playback controller (master) and the flash reader (slave).
// rd_req rises with a valid rd_addr and both hold steady until the one-cycle rd_ack pulse;
// the transfer completes on the clock edge where rd_req and rd_ack are both high.
interface music_playback_ctrl_if #(parameter int ADDR_W = 23);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;

  modport master (output rd_req, output rd_addr, input rd_ack);
  modport slave  (input rd_req, input rd_addr, output rd_ack);
endinterface

// File: rtl/music_cmd_decode.sv
// Turns the rising edge of kybrd_data_ready into a one-cycle decoded command strobe.
module music_cmd_decode
  import music_ctrl_pkg::*;
#(
  parameter bit CASE_INSENSITIVE = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] keyboard_input,
  input  logic       kybrd_data_ready,
  output cmd_t       cmd
);

  logic       ready_q;
  logic [7:0] key;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ready_q <= 1'b0;
    else          ready_q <= kybrd_data_ready;
  end

  always_comb begin
    cmd = CMD_NONE;
    key = fold_case(keyboard_input, CASE_INSENSITIVE);
    if (kybrd_data_ready && !ready_q) begin
      case (key)
        KEY_F:   cmd = CMD_FWD;
        KEY_B:   cmd = CMD_BWD;
        KEY_E:   cmd = CMD_PLAY;
        KEY_D:   cmd = CMD_PAUSE;
        KEY_R:   cmd = CMD_RESTART;
        KEY_U:   cmd = CMD_FASTER;
        KEY_L:   cmd = CMD_SLOWER;
        KEY_N:   cmd = CMD_NORMAL;
        default: cmd = CMD_NONE;
      endcase
    end
  end

endmodule

// File: rtl/music_playback_ctrl.sv
// Playback controller: keyboard-driven transport state, sample-rate tick and flash address walker.
module music_playback_ctrl
  import music_ctrl_pkg::*;
#(
  parameter int                ADDR_W           = 23,
  parameter logic [ADDR_W-1:0] START_ADDR       = 23'h000000,
  parameter logic [ADDR_W-1:0] END_ADDR         = 23'h07FFFF,
  parameter int                DIV_W            = 16,
  parameter int                DIV_NOM          = 1136,
  parameter int                DIV_STEP         = 64,
  parameter int                DIV_MIN          = 568,
  parameter int                DIV_MAX          = 2272,
  parameter bit                LOOP             = 1'b1,
  parameter bit                CASE_INSENSITIVE = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            keyboard_input,
  input  logic                  kybrd_data_ready,
  output logic                  forward,
  output logic                  pause,
  output logic                  restart,
  output logic                  end_pulse,
  output logic                  overrun,
  output logic [DIV_W-1:0]      div_period,
  output play_state_t           state_dbg,
  music_playback_ctrl_if.master rd_if
);

  localparam logic [DIV_W-1:0]  P_NOM  = DIV_W'(DIV_NOM);
  localparam logic [DIV_W-1:0]  P_STEP = DIV_W'(DIV_STEP);
  localparam logic [DIV_W-1:0]  P_MIN  = DIV_W'(DIV_MIN);
  localparam logic [DIV_W-1:0]  P_MAX  = DIV_W'(DIV_MAX);
  localparam logic [DIV_W-1:0]  P_ONE  = DIV_W'(1);
  localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);

  cmd_t              cmd;
  play_state_t       state_q, state_n;
  logic [DIV_W-1:0]  tick_cnt, div_n;
  logic [ADDR_W-1:0] rd_addr_q, addr_n, target;
  logic              rd_req_q, rd_req_n, pend_q, pend_n;
  logic              fwd_n, pause_n, end_n, overrun_n, stop_at_end, tick;

  music_cmd_decode #(.CASE_INSENSITIVE(CASE_INSENSITIVE)) u_decode (
    .clk              (clk),
    .reset_n          (reset_n),
    .keyboard_input   (keyboard_input),
    .kybrd_data_ready (kybrd_data_ready),
    .cmd              (cmd)
  );

  // >= rather than == so a period shrink below the current count still fires promptly.
  assign tick = !pause && (tick_cnt >= div_period - P_ONE);

  always_comb begin
    fwd_n   = forward;
    pause_n = pause;
    div_n   = div_period;
    case (cmd)
      CMD_FWD:    fwd_n   = 1'b1;
      CMD_BWD:    fwd_n   = 1'b0;
      CMD_PLAY:   pause_n = 1'b0;
      CMD_PAUSE:  pause_n = 1'b1;
      CMD_FASTER: div_n   = (div_period < P_MIN + P_STEP) ? P_MIN : div_period - P_STEP;
      CMD_SLOWER: div_n   = (div_period > P_MAX - P_STEP) ? P_MAX : div_period + P_STEP;
      CMD_NORMAL: div_n   = P_NOM;
      default:    ;
    endcase
  end

  assign target = fwd_n ? START_ADDR : END_ADDR;

  always_comb begin
    state_n     = state_q;
    rd_req_n    = rd_req_q;
    addr_n      = rd_addr_q;
    pend_n      = pend_q;
    end_n       = 1'b0;
    overrun_n   = overrun;
    stop_at_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd == CMD_RESTART) addr_n = target;
        if (tick) begin
          rd_req_n = 1'b1;
          state_n  = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (tick) overrun_n = 1'b1;
        if (cmd == CMD_RESTART) pend_n = 1'b1;
        if (rd_if.rd_ack) begin
          rd_req_n = 1'b0;
          pend_n   = 1'b0;
          state_n  = IDLE;
          if (pend_q || (cmd == CMD_RESTART)) begin
            addr_n = target;
          end else if (fwd_n) begin
            if (rd_addr_q == END_ADDR) begin
              addr_n      = LOOP ? START_ADDR : END_ADDR;
              end_n       = 1'b1;
              stop_at_end = ~LOOP;
            end else begin
              addr_n = rd_addr_q + A_ONE;
            end
          end else begin
            if (rd_addr_q == START_ADDR) begin
              addr_n      = LOOP ? END_ADDR : START_ADDR;
              end_n       = 1'b1;
              stop_at_end = ~LOOP;
            end else begin
              addr_n = rd_addr_q - A_ONE;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rd_req_q   <= 1'b0;
      rd_addr_q  <= START_ADDR;
      pend_q     <= 1'b0;
      forward    <= 1'b1;
      pause      <= 1'b1;
      restart    <= 1'b0;
      end_pulse  <= 1'b0;
      overrun    <= 1'b0;
      div_period <= P_NOM;
      tick_cnt   <= '0;
    end else begin
      state_q    <= state_n;
      rd_req_q   <= rd_req_n;
      rd_addr_q  <= addr_n;
      pend_q     <= pend_n;
      forward    <= fwd_n;
      pause      <= pause_n | stop_at_end;
      restart    <= (cmd == CMD_RESTART);
      end_pulse  <= end_n;
      overrun    <= overrun_n;
      div_period <= div_n;
      tick_cnt   <= (pause || tick) ? '0 : tick_cnt + P_ONE;
    end
  end

  assign rd_if.rd_req  = rd_req_q;
  assign rd_if.rd_addr = rd_addr_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_music_playback_ctrl.sv
// Directed bench for music_playback_ctrl: a looping instance with the default region and a
// one-shot instance over a four-sample region, sharing the keyboard inputs.
module tb_music_playback_ctrl;
  import music_ctrl_pkg::*;

  localparam logic [22:0] END_A = 23'h07FFFF;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  keyboard_input = 8'h00;
  logic        kybrd_data_ready = 1'b0;
  logic        forward, pause, restart, end_pulse, overrun;
  logic        forward0, pause0, restart0, end_pulse0, overrun0;
  logic [15:0] div_period, div_period0;
  play_state_t state_dbg, state_dbg0;
  int          tests_run = 0;
  int          failed = 0;
  logic [22:0] exp_q[$];

  music_playback_ctrl_if #(.ADDR_W(23)) rif ();
  music_playback_ctrl_if #(.ADDR_W(23)) rif0 ();

  music_playback_ctrl dut (
    .clk(clk), .reset_n(reset_n), .keyboard_input(keyboard_input),
    .kybrd_data_ready(kybrd_data_ready), .forward(forward), .pause(pause),
    .restart(restart), .end_pulse(end_pulse), .overrun(overrun),
    .div_period(div_period), .state_dbg(state_dbg), .rd_if(rif)
  );

  music_playback_ctrl #(.START_ADDR(23'd16), .END_ADDR(23'd19), .LOOP(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .keyboard_input(keyboard_input),
    .kybrd_data_ready(kybrd_data_ready), .forward(forward0), .pause(pause0),
    .restart(restart0), .end_pulse(end_pulse0), .overrun(overrun0),
    .div_period(div_period0), .state_dbg(state_dbg0), .rd_if(rif0)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic apply_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // drivers
  task automatic send_key(input logic [7:0] k);
    @(negedge clk);
    keyboard_input   = k;
    kybrd_data_ready = 1'b1;
    @(negedge clk);
    kybrd_data_ready = 1'b0;
  endtask

  task automatic wait_req(input bit which, output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!(which ? rif0.rd_req : rif.rd_req) && n < 2500);
    tests_run++;
    if (!(which ? rif0.rd_req : rif.rd_req)) begin
      failed++; $display("FAIL wait_req_timeout dut%0d got no rd_req after %0d cycles", which, n);
    end
  endtask

  task automatic do_ack(input bit which);
    @(negedge clk);
    if (which) rif0.rd_ack = 1'b1; else rif.rd_ack = 1'b1;
    @(negedge clk);
    rif0.rd_ack = 1'b0;
    rif.rd_ack  = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    apply_reset();
    tests_run++; if (forward !== 1'b1) begin failed++; $display("FAIL reset_forward got=%0b exp=1", forward); end
    tests_run++; if (pause !== 1'b1) begin failed++; $display("FAIL reset_pause got=%0b exp=1", pause); end
    tests_run++; if (restart !== 1'b0) begin failed++; $display("FAIL reset_restart got=%0b exp=0", restart); end
    tests_run++; if (rif.rd_req !== 1'b0) begin failed++; $display("FAIL reset_rd_req got=%0b exp=0", rif.rd_req); end
    tests_run++; if (rif.rd_addr !== 23'h0) begin failed++; $display("FAIL reset_rd_addr got=%h exp=0", rif.rd_addr); end
    tests_run++; if (end_pulse !== 1'b0) begin failed++; $display("FAIL reset_end_pulse got=%0b exp=0", end_pulse); end
    tests_run++; if (overrun !== 1'b0) begin failed++; $display("FAIL reset_overrun got=%0b exp=0", overrun); end
    tests_run++; if (div_period !== 16'd1136) begin failed++; $display("FAIL reset_div got=%0d exp=1136", div_period); end
    tests_run++; if (state_dbg !== IDLE) begin failed++; $display("FAIL reset_state got=%0d exp=IDLE", state_dbg); end
    tests_run++; if (rif0.rd_addr !== 23'd16) begin failed++; $display("FAIL reset_rd_addr0 got=%0d exp=16", rif0.rd_addr); end
  endtask

  task automatic test_play();
    int n;
    @(negedge clk);
    keyboard_input = KEY_E; kybrd_data_ready = 1'b1;
    @(posedge clk); #1;
    tests_run++; if (pause !== 1'b0) begin failed++; $display("FAIL play_pause got=%0b exp=0", pause); end
    @(negedge clk); kybrd_data_ready = 1'b0;
    wait_req(1'b0, n);
    tests_run++; if (n !== 1136) begin failed++; $display("FAIL first_req_latency got=%0d exp=1136", n); end
    exp_q.push_back(23'd0); exp_q.push_back(23'd1); exp_q.push_back(23'd2);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) wait_req(1'b0, n);
      tests_run++;
      if (rif.rd_addr !== exp_q[0]) begin failed++; $display("FAIL play_addr%0d got=%0d exp=%0d", i, rif.rd_addr, exp_q[0]); end
      void'(exp_q.pop_front());
      do_ack(1'b0);
    end
    tests_run++; if (rif.rd_addr !== 23'd3 || rif.rd_req !== 1'b0) begin failed++; $display("FAIL play_after_ack got=%0d/%0b exp=3/0", rif.rd_addr, rif.rd_req); end
    send_key(KEY_D);
    tests_run++; if (pause !== 1'b1) begin failed++; $display("FAIL pause_cmd got=%0b exp=1", pause); end
  endtask

  task automatic test_restart();
    int cnt = 0;
    @(negedge clk);
    keyboard_input = KEY_R; kybrd_data_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin @(negedge clk); if (restart) cnt++; end
    kybrd_data_ready = 1'b0;
    tests_run++; if (cnt !== 1) begin failed++; $display("FAIL restart_held got=%0d pulses exp=1", cnt); end
    tests_run++; if (rif.rd_addr !== 23'd0) begin failed++; $display("FAIL restart_addr got=%0d exp=0", rif.rd_addr); end
    send_key(8'h5A);
    tests_run++; if (restart !== 1'b0 || forward !== 1'b1 || pause !== 1'b1) begin failed++; $display("FAIL ignored_code got=%0b%0b%0b exp=011", restart, forward, pause); end
    send_key(KEY_B);
    send_key(8'h72);
    tests_run++; if (restart !== 1'b1) begin failed++; $display("FAIL lower_r got=%0b exp=1", restart); end
    tests_run++; if (rif.rd_addr !== END_A) begin failed++; $display("FAIL restart_bwd_addr got=%h exp=%h", rif.rd_addr, END_A); end
  endtask

  task automatic test_wrap();
    int n;
    send_key(KEY_F);
    tests_run++; if (forward !== 1'b1) begin failed++; $display("FAIL fwd_cmd got=%0b exp=1", forward); end
    send_key(KEY_E);
    wait_req(1'b0, n);
    tests_run++; if (rif.rd_addr !== END_A) begin failed++; $display("FAIL wrap_req_addr got=%h exp=%h", rif.rd_addr, END_A); end
    do_ack(1'b0);
    tests_run++; if (rif.rd_addr !== 23'd0 || end_pulse !== 1'b1) begin failed++; $display("FAIL fwd_wrap got=%h/%0b exp=0/1", rif.rd_addr, end_pulse); end
    @(negedge clk);
    tests_run++; if (end_pulse !== 1'b0) begin failed++; $display("FAIL end_pulse_width got=%0b exp=0", end_pulse); end
    send_key(KEY_D);
    send_key(KEY_B);
    send_key(KEY_E);
    wait_req(1'b0, n);
    tests_run++; if (rif.rd_addr !== 23'd0) begin failed++; $display("FAIL bwd_req_addr got=%h exp=0", rif.rd_addr); end
    do_ack(1'b0);
    tests_run++; if (rif.rd_addr !== END_A || end_pulse !== 1'b1) begin failed++; $display("FAIL bwd_wrap got=%h/%0b exp=%h/1", rif.rd_addr, end_pulse, END_A); end
    send_key(KEY_D);
  endtask

  task automatic test_speed();
    send_key(KEY_U);
    tests_run++; if (div_period !== 16'd1072) begin failed++; $display("FAIL faster_once got=%0d exp=1072", div_period); end
    repeat (11) send_key(KEY_U);
    tests_run++; if (div_period !== 16'd568) begin failed++; $display("FAIL faster_sat got=%0d exp=568", div_period); end
    repeat (40) send_key(KEY_L);
    tests_run++; if (div_period !== 16'd2272) begin failed++; $display("FAIL slower_sat got=%0d exp=2272", div_period); end
    send_key(KEY_N);
    tests_run++; if (div_period !== 16'd1136) begin failed++; $display("FAIL normal got=%0d exp=1136", div_period); end
  endtask

  task automatic test_overrun();
    int n;
    send_key(KEY_F);
    send_key(KEY_R);
    send_key(KEY_E);
    wait_req(1'b0, n);
    do_ack(1'b0);
    wait_req(1'b0, n);
    tests_run++; if (rif.rd_addr !== 23'd1) begin failed++; $display("FAIL ovr_req_addr got=%0d exp=1", rif.rd_addr); end
    repeat (1200) @(negedge clk);
    tests_run++; if (overrun !== 1'b1) begin failed++; $display("FAIL overrun_set got=%0b exp=1", overrun); end
    tests_run++; if (rif.rd_req !== 1'b1 || rif.rd_addr !== 23'd1 || state_dbg !== WAIT_ACK) begin failed++; $display("FAIL req_held got=%0b/%0d/%0d exp=1/1/1", rif.rd_req, rif.rd_addr, state_dbg); end
    send_key(KEY_R);
    tests_run++; if (rif.rd_addr !== 23'd1) begin failed++; $display("FAIL pend_addr_stable got=%0d exp=1", rif.rd_addr); end
    do_ack(1'b0);
    tests_run++; if (rif.rd_addr !== 23'd0) begin failed++; $display("FAIL pend_restart got=%0d exp=0", rif.rd_addr); end
    tests_run++; if (overrun !== 1'b1) begin failed++; $display("FAIL overrun_sticky got=%0b exp=1", overrun); end
  endtask

  task automatic test_async_reset();
    int n;
    wait_req(1'b0, n);
    do_ack(1'b0);
    wait_req(1'b0, n);
    tests_run++; if (rif.rd_addr !== 23'd1) begin failed++; $display("FAIL ar_req_addr got=%0d exp=1", rif.rd_addr); end
    #2 reset_n = 1'b0;
    #1;
    tests_run++; if (rif.rd_req !== 1'b0 || pause !== 1'b1) begin failed++; $display("FAIL async_req_pause got=%0b/%0b exp=0/1", rif.rd_req, pause); end
    tests_run++; if (rif.rd_addr !== 23'd0 || overrun !== 1'b0) begin failed++; $display("FAIL async_addr_ovr got=%0d/%0b exp=0/0", rif.rd_addr, overrun); end
    apply_reset();
  endtask

  task automatic test_one_shot();
    int n;
    send_key(KEY_E);
    for (int a = 16; a < 19; a++) begin
      wait_req(1'b1, n);
      tests_run++; if (rif0.rd_addr !== 23'(a)) begin failed++; $display("FAIL once_addr got=%0d exp=%0d", rif0.rd_addr, a); end
      do_ack(1'b1);
    end
    wait_req(1'b1, n);
    do_ack(1'b1);
    tests_run++; if (rif0.rd_addr !== 23'd19 || end_pulse0 !== 1'b1 || pause0 !== 1'b1) begin failed++; $display("FAIL once_fwd_end got=%0d/%0b/%0b exp=19/1/1", rif0.rd_addr, end_pulse0, pause0); end
    send_key(KEY_R);
    send_key(KEY_B);
    tests_run++; if (rif0.rd_addr !== 23'd16 || forward0 !== 1'b0) begin failed++; $display("FAIL once_setup got=%0d/%0b exp=16/0", rif0.rd_addr, forward0); end
    send_key(KEY_E);
    wait_req(1'b1, n);
    do_ack(1'b1);
    tests_run++; if (rif0.rd_addr !== 23'd16 || end_pulse0 !== 1'b1 || pause0 !== 1'b1) begin failed++; $display("FAIL once_bwd_end got=%0d/%0b/%0b exp=16/1/1", rif0.rd_addr, end_pulse0, pause0); end
  endtask

  initial begin
    rif.rd_ack  = 1'b0;
    rif0.rd_ack = 1'b0;
    test_reset();
    test_play();
    test_restart();
    test_wrap();
    test_speed();
    test_overrun();
    test_async_reset();
    test_one_shot();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/music_playback_ctrl.md
Name: music_playback_ctrl

Overview:
Next-generation music playback controller for the audio path. It decodes ASCII keyboard commands into play/pause, direction, restart and speed state. It generates a programmable-rate sample tick and walks a sample address through a flash region using a req/ack handshake to the flash reader. It handles wrap-around, optional one-shot playback, pending restarts and overrun detection.

Parameters:
ADDR_W, 23, width of sample address
START_ADDR, 23'h000000, first sample address of song region
END_ADDR, 23'h07FFFF, last sample address of song region (END_ADDR > START_ADDR)
DIV_W, 16, width of tick period register
DIV_NOM, 1136, nominal clk cycles per sample tick (~44 kHz at 50 MHz)
DIV_STEP, 64, period change per faster/slower command
DIV_MIN, 568, minimum period (fastest)
DIV_MAX, 2272, maximum period (slowest)
LOOP, 1, 1 = wrap at region end; 0 = stop (force pause) at region end
CASE_INSENSITIVE, 1, 1 = lowercase letters 0x61-0x7A accepted as their uppercase equivalents

Ports:
clk  in  1  system clock, 50 MHz
reset_n  in  1  asynchronous active-low reset
keyboard_input  in  8  ASCII code currently presented by keyboard interface
kybrd_data_ready  in  1  level; rising edge marks a new keyboard byte
rd_ack  in  1  flash reader has consumed rd_addr (single-cycle pulse)
forward  out  1  1 = forward playback, 0 = backward
pause  out  1  1 = paused
restart  out  1  one-cycle pulse on accepted restart command
rd_req  out  1  read request, held until rd_ack
rd_addr  out  ADDR_W  sample address for current request
end_pulse  out  1  one-cycle pulse when address passes a region boundary
overrun  out  1  sticky; tick arrived while request outstanding
div_period  out  DIV_W  current tick period

Behaviour:
- Reset (async, reset_n=0): forward=1, pause=1, restart=0, rd_req=0, rd_addr=START_ADDR, end_pulse=0, overrun=0, div_period=DIV_NOM, tick counter=0, ready delay reg=0, restart_pend=0, FSM=IDLE.
- Command accept: only when kybrd_data_ready=1 and its registered copy=0 (rising edge). Byte is sampled in that cycle; effects are visible after the next clk edge. A held byte never re-triggers.
- Codes: 'F' 0x46 forward=1; 'B' 0x42 forward=0; 'E' 0x45 pause=0; 'D' 0x44 pause=1; 'R' 0x52 restart; 'U' 0x55 period -= DIV_STEP, saturating at DIV_MIN; 'L' 0x4C period += DIV_STEP, saturating at DIV_MAX; 'N' 0x4E period=DIV_NOM. All other codes are ignored.
- Restart: restart=1 for exactly one cycle. Target address is START_ADDR if forward, else END_ADDR, using the direction value in effect after the command cycle.
  - FSM IDLE: rd_addr is loaded with the target immediately.
  - FSM WAIT_ACK: restart_pend is set; on rd_ack, rd_addr is loaded with the target instead of advancing.
- Tick counter: held at 0 while pause=1. Otherwise it increments each cycle. A tick fires when count >= div_period-1, and the count then returns to 0. Using >= makes period shrinks safe.
- FSM IDLE: on tick, rd_req<=1 and move to WAIT_ACK.
- FSM WAIT_ACK: rd_req stays 1 and rd_addr stays stable. On rd_ack: rd_req<=0, advance the address (or apply the pending restart), return to IDLE. A tick in this state sets overrun=1 (cleared only by reset) and is dropped.
- Advance, forward: addr+1. At END_ADDR the next address is START_ADDR and end_pulse fires.
- Advance, backward: addr-1. At START_ADDR the next address is END_ADDR and end_pulse fires.
- LOOP=0: at the boundary, the address holds at the boundary, end_pulse fires, and pause<=1.
- Pause while WAIT_ACK: the outstanding request still completes; no new ticks are issued.
- Direction change mid-request: applies to the advance at rd_ack.
- Simultaneous command and rd_ack: both take effect in the same cycle; the command's direction and restart take priority over a normal advance.
- rd_ack in IDLE: ignored.

Decomposition:
- Package music_ctrl_pkg: key-code constants (KEY_F, KEY_B, KEY_E, KEY_D, KEY_R, KEY_U, KEY_L, KEY_N), enum play_state_t {IDLE, WAIT_ACK}, enum cmd_t {CMD_NONE, CMD_FWD, CMD_BWD, CMD_PLAY, CMD_PAUSE, CMD_RESTART, CMD_FASTER, CMD_SLOWER, CMD_NORMAL}.
- Sub-module music_cmd_decode: edge detect plus case fold plus decode to a one-cycle cmd_t strobe. The parent holds the state, rate divider and address FSM.

Test Plan:
1. Reset release; send 'E' rising edge with DIV_NOM=1136 -> pause=0; first rd_req 1136 cycles later with rd_addr=0. Ack each request -> addr 0,1,2.
2. Hold 'R' with kybrd_data_ready high for 100 cycles -> restart high exactly 1 cycle. Issue 'r' (0x72) -> accepted as restart.
3. Forward at END_ADDR, ack -> rd_addr=START_ADDR with end_pulse=1. Repeat with 'B' at START_ADDR -> END_ADDR. With LOOP=0 -> addr holds and pause=1.
4. Send 'U' x12 -> div_period saturates at 568. Send 'L' x40 -> saturates at 2272. Send 'N' -> 1136.
5. Withhold rd_ack beyond one tick period -> overrun=1 and remains 1 after ack. 'R' during WAIT_ACK -> next addr=START_ADDR on ack.
6. Assert reset_n=0 mid-WAIT_ACK, asynchronously -> rd_req=0, pause=1, rd_addr=START_ADDR, overrun=0 immediately.
